// File: rtl/texture_loader_pkg.sv
// Shared constants for the host-loaded texture store: command code, address fields, FSM encodings.
package texture_loader_pkg;

  localparam logic [7:0] TEXLOAD_CMD_WRITE = 8'h02;

  localparam int TEX_ADDR_BITS = 13;
  localparam int TEX_SIDE_BIT  = 12;
  localparam int TEX_COL_MSB   = 11;
  localparam int TEX_COL_LSB   = 6;
  localparam int TEX_ROW_MSB   = 5;
  localparam int TEX_ROW_LSB   = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR_HI = 3'd2;
  localparam logic [2:0] ST_ADDR_LO = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_IGNORE  = 3'd5;

endpackage

// File: rtl/texture_loader_spi_sync_edge.sv
// Synchronises SPI sclk/mosi/csb into clk and flags sclk rise and csb rise/fall.
// Latency: 2 clk synchroniser + 1 clk edge detect; no backpressure (free-running sampler).
// Requires f_clk >= 4 * f_sclk.
module spi_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  input  logic spi_csb,
  output logic mosi_s,
  output logic csb_s,
  output logic sclk_rise,
  output logic csb_rise,
  output logic csb_fall
);

  logic sclk_m, sclk_s, sclk_prev;
  logic mosi_m;
  logic csb_m, csb_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_m    <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_m    <= 1'b0;
      mosi_s    <= 1'b0;
      csb_m     <= 1'b0;
      csb_s     <= 1'b0;
      csb_prev  <= 1'b0;
    end else begin
      sclk_m    <= spi_sclk;
      sclk_s    <= sclk_m;
      sclk_prev <= sclk_s;
      mosi_m    <= spi_mosi;
      mosi_s    <= mosi_m;
      csb_m     <= spi_csb;
      csb_s     <= csb_m;
      csb_prev  <= csb_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign csb_rise  = csb_s & ~csb_prev;
  assign csb_fall  = ~csb_s & csb_prev;

endmodule

// File: rtl/texture_loader.sv
// SPI-to-texture-memory write bridge: 02 <addr_hi> <addr_lo> <data...>, auto-incrementing address.
// Latency: we one clk after the 8th sampled sclk rise; no backpressure, host paces via sclk.
// Optional TEXTURE_LOADER_CHECKSUM_EN: 8-bit running sum of data bytes on checksum.
module texture_loader
  import texture_loader_pkg::*;
#(
  parameter int CHANNEL_BITS = 2,
  parameter int ADDR_BITS    = TEX_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      spi_sclk,
  input  logic                      spi_mosi,
  input  logic                      spi_csb,
  output logic                      we,
  output logic [ADDR_BITS-1:0]      waddr,
  output logic [CHANNEL_BITS*3-1:0] wdata,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                checksum
);

  logic mosi_s, csb_s, sclk_rise, csb_rise, csb_fall;

  spi_sync_edge u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_csb   (spi_csb),
    .mosi_s    (mosi_s),
    .csb_s     (csb_s),
    .sclk_rise (sclk_rise),
    .csb_rise  (csb_rise),
    .csb_fall  (csb_fall)
  );

  logic [2:0]           state;
  logic [2:0]           bit_cnt;
  logic [6:0]           shreg;
  logic [ADDR_BITS-1:0] addr;
  logic                 wrote;
  logic [7:0]           rx_byte;
  logic                 byte_done;

  assign rx_byte   = {shreg, mosi_s};
  // csb_s gating makes a simultaneous CSb rise win over a completing byte
  assign byte_done = sclk_rise & ~csb_s & (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
      addr    <= '0;
      wrote   <= 1'b0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (csb_s) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
        busy    <= 1'b0;
        wrote   <= 1'b0;
        if (csb_rise) done <= wrote;
      end else begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= rx_byte[6:0];
        end
        case (state)
          ST_IDLE: if (csb_fall) state <= ST_CMD;
          ST_CMD: if (byte_done) begin
            if (rx_byte == TEXLOAD_CMD_WRITE) begin
              state <= ST_ADDR_HI;
              busy  <= 1'b1;
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_ADDR_HI: if (byte_done) begin
            addr[ADDR_BITS-1:8] <= rx_byte[ADDR_BITS-9:0];
            state               <= ST_ADDR_LO;
          end
          ST_ADDR_LO: if (byte_done) begin
            addr[7:0] <= rx_byte;
            state     <= ST_DATA;
          end
          ST_DATA: if (byte_done) begin
            we    <= 1'b1;
            waddr <= addr;
            wdata <= rx_byte[CHANNEL_BITS*3-1:0];
            addr  <= addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
            wrote <= 1'b1;
          end
          default: state <= ST_IGNORE;
        endcase
      end
    end
  end

`ifdef TEXTURE_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 8'h00;
    end else if (state == ST_CMD && byte_done && rx_byte == TEXLOAD_CMD_WRITE) begin
      checksum <= 8'h00;
    end else if (state == ST_DATA && byte_done) begin
      checksum <= checksum + rx_byte;
    end
  end
`else
  assign checksum = 8'h00;
`endif

endmodule
